// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry framer.
// The frame length depends on TELEM_CHECKSUM_EN (one trailing CHK byte when defined).
package telem_pkg;

   localparam int unsigned TELEM_DWIDTH_DEFAULT    = 64;
   localparam logic [7:0]  TELEM_SYNC_BYTE_DEFAULT = 8'hA5;

   // SYNC and SEQ precede the payload
   localparam int unsigned TELEM_HDR_BYTES = 2;
`ifdef TELEM_CHECKSUM_EN
   localparam int unsigned TELEM_CHK_BYTES = 1;
`else
   localparam int unsigned TELEM_CHK_BYTES = 0;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StLatch,
      StSend,
      StWaitDone,
      StNext
   } telem_state_e;

   function automatic int unsigned telem_frame_len(input int unsigned dwidth);
      return TELEM_HDR_BYTES + dwidth / 8 + TELEM_CHK_BYTES;
   endfunction

endpackage

// File: rtl/telem_checksum.sv
// 8-bit modulo-256 running sum of the SEQ and payload bytes of a frame.
// Only instantiated when TELEM_CHECKSUM_EN is defined.
module telem_checksum (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr_i,
   input  logic       acc_i,
   input  logic [7:0] byte_i,
   output logic [7:0] sum_o
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;

   // Clear takes priority over accumulate
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = 8'h00;
      end else if (acc_i) begin
         sum_d = sum_q + byte_i;
      end
   end

   // Sum register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/telemetry_framer.sv
// Pops words from a FIFO and sends each as a byte frame over a UART transmitter:
// SYNC_BYTE, SEQ, payload bytes MSB first, and CHK when TELEM_CHECKSUM_EN is defined.
module telemetry_framer
   import telem_pkg::*;
#(
   parameter int unsigned DWIDTH    = TELEM_DWIDTH_DEFAULT,
   parameter logic [7:0]  SYNC_BYTE = TELEM_SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fsm_en,
   input  logic [DWIDTH-1:0] fifo_rd_data,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic              uart_start_tx,
   output logic [7:0]        uart_tx_din,
   input  logic              uart_tx_done,
   output logic [15:0]       frame_count
);

   localparam int unsigned NumData  = DWIDTH / 8;
   localparam int unsigned FrameLen = telem_frame_len(DWIDTH);
   localparam int unsigned IdxW     = $clog2(FrameLen);

   localparam logic [IdxW-1:0] SeqIdx      = IdxW'(1);
   localparam logic [IdxW-1:0] DataLastIdx = IdxW'(TELEM_HDR_BYTES + NumData - 1);
   localparam logic [IdxW-1:0] LastIdx     = IdxW'(FrameLen - 1);

   telem_state_e      state_q, state_d;
   logic [DWIDTH-1:0] shift_q, shift_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [IdxW-1:0]   idx_inc;
   logic [7:0]        din_q, din_d;
   logic [7:0]        seq_q, seq_d;
   logic [15:0]       cnt_q, cnt_d;

`ifdef TELEM_CHECKSUM_EN
   logic              chk_clr;
   logic              chk_acc;
   logic [7:0]        chk_sum;
`endif

   // Next-state, datapath and strobe decode. The byte to send is loaded into din_q on the
   // way into SEND so it stays constant until the transmitter reports done.
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      idx_d         = idx_q;
      din_d         = din_q;
      seq_d         = seq_q;
      cnt_d         = cnt_q;
      fifo_rd_en    = 1'b0;
      uart_start_tx = 1'b0;
      idx_inc       = idx_q + IdxW'(1);
`ifdef TELEM_CHECKSUM_EN
      chk_clr       = 1'b0;
      chk_acc       = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (fsm_en && !fifo_empty) begin
               state_d = StPop;
            end
         end
         StPop: begin
            fifo_rd_en = 1'b1;
            state_d    = StLatch;
         end
         StLatch: begin
            shift_d = fifo_rd_data;
            idx_d   = '0;
            din_d   = SYNC_BYTE;
`ifdef TELEM_CHECKSUM_EN
            chk_clr = 1'b1;
`endif
            state_d = StSend;
         end
         StSend: begin
            uart_start_tx = 1'b1;
            state_d       = StWaitDone;
         end
         StWaitDone: begin
            if (uart_tx_done) begin
               state_d = StNext;
            end
         end
         StNext: begin
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               seq_d   = seq_q + 8'd1;
               cnt_d   = cnt_q + 16'd1;
               state_d = StIdle;
            end else begin
               idx_d   = idx_inc;
               state_d = StSend;
               if (idx_inc == SeqIdx) begin
                  din_d = seq_q;
`ifdef TELEM_CHECKSUM_EN
                  chk_acc = 1'b1;
`endif
               end else if (idx_inc <= DataLastIdx) begin
                  // Payload leaves MSB first; shift the next byte into the top slot
                  din_d   = shift_q[DWIDTH-1 -: 8];
                  shift_d = shift_q << 8;
`ifdef TELEM_CHECKSUM_EN
                  chk_acc = 1'b1;
`endif
               end
`ifdef TELEM_CHECKSUM_EN
               else begin
                  // Sum already holds SEQ and every payload byte at this point
                  din_d = chk_sum;
               end
`endif
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any frame in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         din_q   <= 8'h00;
         seq_q   <= 8'h00;
         cnt_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         din_q   <= din_d;
         seq_q   <= seq_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef TELEM_CHECKSUM_EN
   telem_checksum u_checksum (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (chk_clr),
      .acc_i   (chk_acc),
      .byte_i  (din_d),
      .sum_o   (chk_sum)
   );
`endif

   assign uart_tx_din = din_q;
   assign frame_count = cnt_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer with a FIFO model and a UART responder.
// Expected frames follow TELEM_CHECKSUM_EN (11 bytes with CHK, 10 without).
`timescale 1ns/1ps
module tb_telemetry_framer;

   localparam int DW = 64;
`ifdef TELEM_CHECKSUM_EN
   localparam int         FRAME_LEN = 11;
   localparam logic [7:0] LAT_LAST  = 8'h25;
   localparam logic [7:0] RST_LAST  = 8'h9F;
`else
   localparam int         FRAME_LEN = 10;
   localparam logic [7:0] LAT_LAST  = 8'h08;
   localparam logic [7:0] RST_LAST  = 8'h01;
`endif

   logic          clk          = 1'b0;
   logic          reset_n      = 1'b0;
   logic          fsm_en       = 1'b0;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic          uart_start_tx;
   logic [7:0]    uart_tx_din;
   logic          uart_tx_done = 1'b0;
   logic [15:0]   frame_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_single [0:10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12,
                                     8'h00, 8'h00, 8'h00, 8'h0F, 8'h21};

   // FIFO model
   logic [DW-1:0] fifo_mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;

   // Monitor / responder state
   int         cyc         = 0;
   int         rd_cnt      = 0;
   int         last_rd_cyc = 0;
   int         rx_cnt      = 0;
   int         start_err   = 0;
   int         din_err     = 0;
   logic [7:0] rx_byte [0:4095];
   int         rx_cyc  [0:4095];
   int         done_dly    = 1;
   int         spur_req    = 0;
   int         spur_ack    = 0;
   logic       busy        = 1'b0;
   int         busy_cnt    = 0;
   logic [7:0] busy_byte   = 8'h00;

   always #5 clk = ~clk;

   telemetry_framer #(
      .DWIDTH    (64),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fsm_en        (fsm_en),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .uart_start_tx (uart_start_tx),
      .uart_tx_din   (uart_tx_din),
      .uart_tx_done  (uart_tx_done),
      .frame_count   (frame_count)
   );

   assign fifo_empty = (wr_ptr == rd_ptr);

   // Read data appears one cycle after the pop strobe
   always @(posedge clk) begin
      if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
         fifo_rd_data <= fifo_mem[rd_ptr % 64];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   // UART responder and output monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         rd_cnt      <= rd_cnt + 1;
         last_rd_cyc <= cyc;
      end
      if (!reset_n) begin
         busy         <= 1'b0;
         busy_cnt     <= 0;
         uart_tx_done <= 1'b0;
      end else if (uart_start_tx) begin
         if (busy) start_err <= start_err + 1;
         rx_byte[rx_cnt % 4096] <= uart_tx_din;
         rx_cyc[rx_cnt % 4096]  <= cyc;
         rx_cnt       <= rx_cnt + 1;
         busy         <= 1'b1;
         busy_cnt     <= done_dly;
         busy_byte    <= uart_tx_din;
         uart_tx_done <= 1'b0;
      end else if (uart_tx_done) begin
         uart_tx_done <= 1'b0;
         busy         <= 1'b0;
      end else if (busy) begin
         if (uart_tx_din !== busy_byte) din_err <= din_err + 1;
         if (busy_cnt <= 1) uart_tx_done <= 1'b1;
         else busy_cnt <= busy_cnt - 1;
      end else if (spur_req != spur_ack) begin
         spur_ack     <= spur_ack + 1;
         uart_tx_done <= 1'b1;
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      fifo_mem[wr_ptr % 64] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_rx(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (rx_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_frames(input logic [15:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (frame_count == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      fsm_en  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (fifo_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en);
      end
      n_tests++;
      if (uart_start_tx !== 1'b0) begin
         n_fail++; $display("FAIL reset_start: got %b want 0", uart_start_tx);
      end
      n_tests++;
      if (uart_tx_din !== 8'h00) begin
         n_fail++; $display("FAIL reset_din: got %h want 00", uart_tx_din);
      end
      n_tests++;
      if (frame_count !== 16'h0000) begin
         n_fail++; $display("FAIL reset_frame_count: got %h want 0000", frame_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (rd_cnt !== 0 || rx_cnt !== 0) begin
         n_fail++; $display("FAIL reset_idle: got rd=%0d rx=%0d want 0 0", rd_cnt, rx_cnt);
      end
   endtask

   task automatic test_single_frame();
      int base;
      bit ok;
      base     = rx_cnt;
      done_dly = 1;
      push_word(64'h0000_0012_0000_000F);
      fsm_en = 1'b1;
      wait_frames(16'd1, 2000, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL single_timeout: frame_count %0d want 1", frame_count);
      end
      repeat (5) @(posedge clk);
      #1;
      n_tests++;
      if (rx_cnt - base !== FRAME_LEN) begin
         n_fail++; $display("FAIL single_len: got %0d want %0d", rx_cnt - base, FRAME_LEN);
      end
      for (int i = 0; i < FRAME_LEN; i++) begin
         n_tests++;
         if (rx_byte[(base + i) % 4096] !== exp_single[i]) begin
            n_fail++;
            $display("FAIL single_byte%0d: got %h want %h", i, rx_byte[(base + i) % 4096],
                     exp_single[i]);
         end
      end
      n_tests++;
      if (frame_count !== 16'd1) begin
         n_fail++; $display("FAIL single_count: got %0d want 1", frame_count);
      end
      fsm_en = 1'b0;
   endtask

   task automatic test_latency_handshake();
      int base;
      int rd0;
      bit ok;
      base     = rx_cnt;
      rd0      = rd_cnt;
      done_dly = 40;
      fsm_en   = 1'b1;
      // A done pulse while idle must not move anything
      spur_req = spur_req + 1;
      repeat (5) @(posedge clk);
      #1;
      n_tests++;
      if (rx_cnt !== base || rd_cnt !== rd0 || frame_count !== 16'd1) begin
         n_fail++;
         $display("FAIL spurious_done: got rx=%0d rd=%0d fc=%0d want %0d %0d 1",
                  rx_cnt, rd_cnt, frame_count, base, rd0);
      end
      push_word(64'h0102_0304_0506_0708);
      wait_frames(16'd2, FRAME_LEN * 60 + 50, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL latency_timeout: frame_count %0d want 2", frame_count);
      end
      repeat (5) @(posedge clk);
      #1;
      n_tests++;
      if (rd_cnt - rd0 !== 1) begin
         n_fail++; $display("FAIL rd_en_width: got %0d cycles want 1", rd_cnt - rd0);
      end
      n_tests++;
      if (rx_cyc[base % 4096] - last_rd_cyc !== 2) begin
         n_fail++;
         $display("FAIL pop_to_start: got %0d want 2", rx_cyc[base % 4096] - last_rd_cyc);
      end
      n_tests++;
      if (rx_cnt - base !== FRAME_LEN) begin
         n_fail++; $display("FAIL start_count: got %0d want %0d", rx_cnt - base, FRAME_LEN);
      end
      n_tests++;
      if (start_err !== 0) begin
         n_fail++; $display("FAIL start_before_done: got %0d want 0", start_err);
      end
      n_tests++;
      if (din_err !== 0) begin
         n_fail++; $display("FAIL din_stable: got %0d changes want 0", din_err);
      end
      n_tests++;
      if (rx_byte[(base + 1) % 4096] !== 8'h01) begin
         n_fail++; $display("FAIL lat_seq: got %h want 01", rx_byte[(base + 1) % 4096]);
      end
      n_tests++;
      if (rx_byte[(base + 2) % 4096] !== 8'h01 || rx_byte[(base + 9) % 4096] !== 8'h08) begin
         n_fail++;
         $display("FAIL lat_msb_first: got %h..%h want 01..08",
                  rx_byte[(base + 2) % 4096], rx_byte[(base + 9) % 4096]);
      end
      n_tests++;
      if (rx_byte[(base + FRAME_LEN - 1) % 4096] !== LAT_LAST) begin
         n_fail++;
         $display("FAIL lat_last: got %h want %h", rx_byte[(base + FRAME_LEN - 1) % 4096],
                  LAT_LAST);
      end
      fsm_en   = 1'b0;
      done_dly = 1;
   endtask

   task automatic test_enable_drop();
      int base;
      int base2;
      int rd0;
      bit ok;
      base = rx_cnt;
      rd0  = rd_cnt;
      push_word(64'hDEAD_BEEF_0102_0304);
      push_word(64'h1111_2222_3333_4444);
      fsm_en = 1'b1;
      wait_rx(base + 3, 500, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL drop_wait_byte3: got %0d bytes want 3", rx_cnt - base);
      end
      fsm_en = 1'b0;
      wait_frames(16'd3, 1000, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL drop_timeout: frame_count %0d want 3", frame_count);
      end
      repeat (30) @(posedge clk);
      #1;
      n_tests++;
      if (rx_cnt - base !== FRAME_LEN) begin
         n_fail++; $display("FAIL drop_len: got %0d want %0d", rx_cnt - base, FRAME_LEN);
      end
      n_tests++;
      if (rd_cnt - rd0 !== 1 || fifo_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_no_pop: got pops=%0d empty=%b want 1 0", rd_cnt - rd0, fifo_empty);
      end
      n_tests++;
      if (rx_byte[(base + 1) % 4096] !== 8'h02 || rx_byte[(base + 2) % 4096] !== 8'hDE) begin
         n_fail++;
         $display("FAIL drop_frame: got seq=%h d0=%h want 02 DE",
                  rx_byte[(base + 1) % 4096], rx_byte[(base + 2) % 4096]);
      end
      base2  = rx_cnt;
      fsm_en = 1'b1;
      wait_frames(16'd4, 1000, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL resume_timeout: frame_count %0d want 4", frame_count);
      end
      n_tests++;
      if (rx_byte[(base2 + 1) % 4096] !== 8'h03 || rx_byte[(base2 + 2) % 4096] !== 8'h11) begin
         n_fail++;
         $display("FAIL resume_frame: got seq=%h d0=%h want 03 11",
                  rx_byte[(base2 + 1) % 4096], rx_byte[(base2 + 2) % 4096]);
      end
      fsm_en = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int base;
      int base2;
      bit ok;
      base = rx_cnt;
      push_word(64'h5566_7788_99AA_BBCC);
      push_word(64'hC0DE_0000_0000_0001);
      fsm_en = 1'b1;
      wait_rx(base + 5, 500, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL rst_wait_byte5: got %0d bytes want 5", rx_cnt - base);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (fifo_rd_en !== 1'b0 || uart_start_tx !== 1'b0 || uart_tx_din !== 8'h00 ||
          frame_count !== 16'h0000) begin
         n_fail++;
         $display("FAIL rst_outputs: got rd=%b st=%b din=%h fc=%h want 0 0 00 0000",
                  fifo_rd_en, uart_start_tx, uart_tx_din, frame_count);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      base2   = rx_cnt;
      wait_frames(16'd1, 1000, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL rst_resume_timeout: frame_count %0d want 1", frame_count);
      end
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (rx_cnt - base2 !== FRAME_LEN) begin
         n_fail++; $display("FAIL rst_len: got %0d want %0d", rx_cnt - base2, FRAME_LEN);
      end
      n_tests++;
      if (rx_byte[base2 % 4096] !== 8'hA5 || rx_byte[(base2 + 1) % 4096] !== 8'h00 ||
          rx_byte[(base2 + 2) % 4096] !== 8'hC0) begin
         n_fail++;
         $display("FAIL rst_header: got %h %h %h want A5 00 C0", rx_byte[base2 % 4096],
                  rx_byte[(base2 + 1) % 4096], rx_byte[(base2 + 2) % 4096]);
      end
      n_tests++;
      if (rx_byte[(base2 + FRAME_LEN - 1) % 4096] !== RST_LAST) begin
         n_fail++;
         $display("FAIL rst_last: got %h want %h", rx_byte[(base2 + FRAME_LEN - 1) % 4096],
                  RST_LAST);
      end
      fsm_en = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_wrap();
      int base;
      bit ok;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n  = 1'b1;
      done_dly = 1;
      fsm_en   = 1'b1;
      base     = rx_cnt;
      ok       = 1'b1;
      for (int f = 0; f < 257; f++) begin
         push_word({8'(f), 56'h0});
         wait_frames(16'(f + 1), 200, ok);
         if (!ok) break;
      end
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL wrap_timeout: frame_count %0d want 257", frame_count);
      end
      n_tests++;
      if (frame_count !== 16'd257) begin
         n_fail++; $display("FAIL wrap_count: got %0d want 257", frame_count);
      end
      n_tests++;
      if (rx_byte[(base + 255 * FRAME_LEN + 1) % 4096] !== 8'hFF) begin
         n_fail++;
         $display("FAIL wrap_seq256: got %h want FF", rx_byte[(base + 255 * FRAME_LEN + 1) % 4096]);
      end
      n_tests++;
      if (rx_byte[(base + 256 * FRAME_LEN + 1) % 4096] !== 8'h00) begin
         n_fail++;
         $display("FAIL wrap_seq257: got %h want 00", rx_byte[(base + 256 * FRAME_LEN + 1) % 4096]);
      end
      n_tests++;
      if (rx_cnt - base !== 257 * FRAME_LEN) begin
         n_fail++; $display("FAIL wrap_bytes: got %0d want %0d", rx_cnt - base, 257 * FRAME_LEN);
      end
      fsm_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_latency_handshake();
      test_enable_drop();
      test_reset_mid_frame();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/telemetry_framer.md
TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

Interface
REQ-001 Parameter DWIDTH, default 64, SHALL set the FIFO word width in bits and SHALL be a multiple of 8.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, SHALL set the first byte of every frame.
REQ-003 clk  input  1  SHALL be the single system clock; all logic is rising-edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fsm_en  input  1  SHALL be the telemetry enable, driven from the UART enable switch.
REQ-006 fifo_rd_data  input  DWIDTH  SHALL be the FIFO read data, valid one cycle after fifo_rd_en.
REQ-007 fifo_empty  input  1  SHALL be the FIFO empty flag.
REQ-008 fifo_rd_en  output  1  SHALL be the FIFO pop strobe, one cycle wide.
REQ-009 uart_start_tx  output  1  SHALL be the one-cycle start pulse to uart_tx.
REQ-010 uart_tx_din  output  8  SHALL be the byte to transmit, held stable from the start pulse until done.
REQ-011 uart_tx_done  input  1  SHALL be the one-cycle byte-complete pulse from uart_tx.
REQ-012 frame_count  output  16  SHALL be the number of frames completed since reset, wrapping at 16'hFFFF.

Function
REQ-013 The frame SHALL be sent in this order: SYNC_BYTE, SEQ, then the DWIDTH/8 data bytes MSB first, then CHK when TELEM_CHECKSUM_EN is defined.
REQ-014 The FSM SHALL use the states IDLE, POP, LATCH, SEND, WAIT_DONE and NEXT.
REQ-015 IDLE->POP SHALL occur when fsm_en=1 and fifo_empty=0; otherwise the FSM SHALL remain in IDLE.
REQ-016 In POP, fifo_rd_en SHALL be 1 for exactly one cycle, and the next state SHALL be LATCH.
REQ-017 In LATCH, fifo_rd_data SHALL be captured into a shift register, the byte index SHALL be cleared, and the next state SHALL be SEND.
REQ-018 In SEND, uart_start_tx SHALL be 1 for one cycle with uart_tx_din set to the current byte, and the next state SHALL be WAIT_DONE.
REQ-019 WAIT_DONE SHALL hold until uart_tx_done=1, then go to NEXT; a second start SHALL never be issued before done.
REQ-020 NEXT SHALL advance the byte index. If bytes remain, the next state SHALL be SEND; otherwise SEQ and frame_count SHALL increment and the next state SHALL be IDLE.
REQ-021 Latency SHALL be fixed: condition seen in IDLE at cycle N -> fifo_rd_en at N+1 -> first uart_start_tx at N+3.
REQ-022 SEQ SHALL be 8 bits, start at 0, increment once per completed frame and wrap 255->0.
REQ-023 CHK SHALL be the sum modulo 256 of SEQ and all data bytes; SYNC_BYTE SHALL be excluded.
REQ-024 Deasserting fsm_en mid-frame SHALL NOT abort the frame; the block SHALL finish it and then stay in IDLE.
REQ-025 fifo_empty asserting mid-frame SHALL be ignored until the block is back in IDLE.
REQ-026 A uart_tx_done pulse outside WAIT_DONE SHALL be ignored.

Reset
REQ-027 While reset_n=0, the state SHALL be IDLE, and fifo_rd_en, uart_start_tx, uart_tx_din, SEQ, frame_count and the checksum SHALL all be 0.
REQ-028 An assertion of reset_n mid-frame SHALL abandon the frame immediately; no partial-frame resume SHALL occur.

Configuration
REQ-029 With the macro TELEM_CHECKSUM_EN defined, the frame SHALL be 2+DWIDTH/8+1 bytes and include CHK.
REQ-030 Without TELEM_CHECKSUM_EN, the frame SHALL be 2+DWIDTH/8 bytes, and no checksum logic SHALL be synthesized.

Structure
REQ-031 Package telem_pkg SHALL hold the state enum type, the SYNC_BYTE default, and the frame-length constants.
REQ-032 Sub-module telem_checksum SHALL hold the 8-bit clear/accumulate register and SHALL be instantiated only under TELEM_CHECKSUM_EN.

Verification
REQ-033 Single frame: reset, push 64'h0000_0012_0000_000F, fsm_en=1 -> the bytes A5,00,00,00,00,12,00,00,00,0F,21 SHALL be sent, then frame_count=1.
REQ-034 Latency and handshake: fifo_rd_en SHALL be high exactly 1 cycle; the first start SHALL occur 2 cycles after the pop; done delayed 1085x10 clocks -> start count SHALL equal byte count, and din SHALL be stable throughout.
REQ-035 Wrap: send 257 frames -> the SEQ of frame 257 SHALL be 00, and frame_count SHALL be 257.
REQ-036 Enable drop: fsm_en=0 after byte 3 with 2 words queued -> the current frame SHALL complete, and no further fifo_rd_en SHALL occur.
REQ-037 Reset mid-frame: reset_n low during byte 5 -> all outputs SHALL be 0; after release with the FIFO non-empty, the next frame SHALL start with A5 and SEQ 00.
REQ-038 Macro off: the REQ-033 stimulus without TELEM_CHECKSUM_EN -> exactly 10 bytes SHALL be sent, ending in 0F.
